// File: rtl/gsu_cart_mem_responder.sv
// SRAM-style ROM/BSRAM strobe front end for the GSU mapper: turns strobe events into
// single-beat req/ack memory accesses and holds the returned read data like an async SRAM.
module gsu_cart_mem_responder #(
    parameter logic [23:0] BSRAM_BASE = 24'hE00000,
    parameter logic [23:0] ROM_BASE   = 24'h000000
) (
    input  logic        MCLK,
    input  logic        RST_N,
    input  logic [22:0] ROM_ADDR,
    input  logic        ROM_CE_N,
    input  logic        ROM_OE_N,
    input  logic        ROM_WORD,
    output logic [15:0] ROM_Q,
    input  logic [19:0] BSRAM_ADDR,
    input  logic [7:0]  BSRAM_D,
    input  logic        BSRAM_CE_N,
    input  logic        BSRAM_OE_N,
    input  logic        BSRAM_WE_N,
    output logic [7:0]  BSRAM_Q,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [23:0] MEM_ADDR,
    output logic [7:0]  MEM_DIN,
    input  logic [15:0] MEM_Q,
    input  logic        MEM_ACK,
    output logic        BUSY
);

    typedef enum logic [1:0] {IDLE, ROM_RD, RAM_RD, RAM_WR} state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_rom_ce_n_d, r_rom_oe_n_d;
    logic        r_bs_ce_n_d, r_bs_oe_n_d, r_bs_we_n_d;
    logic [22:0] r_rom_addr_d;
    logic [19:0] r_bs_addr_d;
    logic [7:0]  r_bs_d_d;

    logic        r_rom_pend, r_rd_pend, r_wr_pend;
    logic [22:0] r_rom_lat_addr;
    logic        r_rom_lat_word;
    logic [19:0] r_rd_lat_addr;
    logic [19:0] r_wr_lat_addr;
    logic [7:0]  r_wr_lat_data;

    logic        r_cur_sel;
    logic        r_cur_word;
    logic        r_mem_req, r_mem_we;
    logic [23:0] r_mem_addr;
    logic [7:0]  r_mem_din;
    logic [15:0] r_rom_q;
    logic [7:0]  r_bsram_q;

    logic        w_rom_ev, w_rd_ev, w_wr_ev;
    logic        w_issue_rom, w_issue_rd, w_issue_wr, w_done;
    logic [7:0]  w_byte;

    // An enabled read that stays on the same address is one access, not one per cycle.
    assign w_rom_ev = !ROM_CE_N && !ROM_OE_N &&
                      ((r_rom_ce_n_d || r_rom_oe_n_d) || (ROM_ADDR != r_rom_addr_d));
    assign w_rd_ev  = !BSRAM_CE_N && !BSRAM_OE_N && BSRAM_WE_N &&
                      ((r_bs_ce_n_d || r_bs_oe_n_d || !r_bs_we_n_d) ||
                       (BSRAM_ADDR != r_bs_addr_d));
    assign w_wr_ev  = BSRAM_WE_N && !r_bs_we_n_d && !r_bs_ce_n_d;

    always_comb begin
        w_state_next = r_state;
        w_issue_rom  = 1'b0;
        w_issue_rd   = 1'b0;
        w_issue_wr   = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_wr_pend) begin
                    w_issue_wr   = 1'b1;
                    w_state_next = RAM_WR;
                end else if (r_rom_pend) begin
                    w_issue_rom  = 1'b1;
                    w_state_next = ROM_RD;
                end else if (r_rd_pend) begin
                    w_issue_rd   = 1'b1;
                    w_state_next = RAM_RD;
                end
            end
            default: begin
                if (MEM_ACK && r_mem_req) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end
            end
        endcase
    end

    assign w_byte = r_cur_sel ? MEM_Q[15:8] : MEM_Q[7:0];

    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rom_ce_n_d   <= 1'b1;
            r_rom_oe_n_d   <= 1'b1;
            r_bs_ce_n_d    <= 1'b1;
            r_bs_oe_n_d    <= 1'b1;
            r_bs_we_n_d    <= 1'b1;
            r_rom_addr_d   <= '0;
            r_bs_addr_d    <= '0;
            r_bs_d_d       <= '0;
            r_rom_pend     <= 1'b0;
            r_rd_pend      <= 1'b0;
            r_wr_pend      <= 1'b0;
            r_rom_lat_addr <= '0;
            r_rom_lat_word <= 1'b0;
            r_rd_lat_addr  <= '0;
            r_wr_lat_addr  <= '0;
            r_wr_lat_data  <= '0;
            r_cur_sel      <= 1'b0;
            r_cur_word     <= 1'b0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_din      <= '0;
            r_rom_q        <= '0;
            r_bsram_q      <= '0;
        end else begin
            r_rom_ce_n_d <= ROM_CE_N;
            r_rom_oe_n_d <= ROM_OE_N;
            r_bs_ce_n_d  <= BSRAM_CE_N;
            r_bs_oe_n_d  <= BSRAM_OE_N;
            r_bs_we_n_d  <= BSRAM_WE_N;
            r_rom_addr_d <= ROM_ADDR;
            r_bs_addr_d  <= BSRAM_ADDR;
            r_bs_d_d     <= BSRAM_D;

            // A fresh event re-arms its flag even in the cycle the old one is issued.
            if (w_rom_ev) begin
                r_rom_pend     <= 1'b1;
                r_rom_lat_addr <= ROM_ADDR;
                r_rom_lat_word <= ROM_WORD;
            end else if (w_issue_rom) begin
                r_rom_pend <= 1'b0;
            end
            if (w_rd_ev) begin
                r_rd_pend     <= 1'b1;
                r_rd_lat_addr <= BSRAM_ADDR;
            end else if (w_issue_rd) begin
                r_rd_pend <= 1'b0;
            end
            if (w_wr_ev) begin
                r_wr_pend     <= 1'b1;
                r_wr_lat_addr <= r_bs_addr_d;
                r_wr_lat_data <= r_bs_d_d;
            end else if (w_issue_wr) begin
                r_wr_pend <= 1'b0;
            end

            if (w_issue_wr) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b1;
                r_mem_addr <= BSRAM_BASE + {4'b0, r_wr_lat_addr};
                r_mem_din  <= r_wr_lat_data;
            end else if (w_issue_rom) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= ROM_BASE + {1'b0, r_rom_lat_addr};
                r_mem_din  <= '0;
                r_cur_sel  <= r_rom_lat_addr[0];
                r_cur_word <= r_rom_lat_word;
            end else if (w_issue_rd) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= BSRAM_BASE + {4'b0, r_rd_lat_addr};
                r_mem_din  <= '0;
                r_cur_sel  <= r_rd_lat_addr[0];
            end else if (w_done) begin
                r_mem_req <= 1'b0;
            end

            if (w_done && r_state == ROM_RD) begin
                r_rom_q <= r_cur_word ? MEM_Q : {8'h00, w_byte};
            end
            if (w_done && r_state == RAM_RD) begin
                r_bsram_q <= w_byte;
            end
        end
    end

    assign MEM_REQ  = r_mem_req;
    assign MEM_WE   = r_mem_we;
    assign MEM_ADDR = r_mem_addr;
    assign MEM_DIN  = r_mem_din;
    assign ROM_Q    = r_rom_q;
    assign BSRAM_Q  = r_bsram_q;
    assign BUSY     = (r_state != IDLE) | r_rom_pend | r_rd_pend | r_wr_pend;

endmodule

// File: tb/tb_gsu_cart_mem_responder.sv
// Directed bench for gsu_cart_mem_responder: hand-computed expectations, one line per check.
module tb_gsu_cart_mem_responder;

    logic        MCLK = 1'b0;
    logic        RST_N;
    logic [22:0] ROM_ADDR;
    logic        ROM_CE_N, ROM_OE_N, ROM_WORD;
    logic [15:0] ROM_Q;
    logic [19:0] BSRAM_ADDR;
    logic [7:0]  BSRAM_D;
    logic        BSRAM_CE_N, BSRAM_OE_N, BSRAM_WE_N;
    logic [7:0]  BSRAM_Q;
    logic        MEM_REQ, MEM_WE;
    logic [23:0] MEM_ADDR;
    logic [7:0]  MEM_DIN;
    logic [15:0] MEM_Q;
    logic        MEM_ACK;
    logic        BUSY;

    int checks   = 0;
    int failures = 0;

    gsu_cart_mem_responder dut (
        .MCLK(MCLK), .RST_N(RST_N),
        .ROM_ADDR(ROM_ADDR), .ROM_CE_N(ROM_CE_N), .ROM_OE_N(ROM_OE_N),
        .ROM_WORD(ROM_WORD), .ROM_Q(ROM_Q),
        .BSRAM_ADDR(BSRAM_ADDR), .BSRAM_D(BSRAM_D), .BSRAM_CE_N(BSRAM_CE_N),
        .BSRAM_OE_N(BSRAM_OE_N), .BSRAM_WE_N(BSRAM_WE_N), .BSRAM_Q(BSRAM_Q),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN),
        .MEM_Q(MEM_Q), .MEM_ACK(MEM_ACK), .BUSY(BUSY)
    );

    always #5 MCLK = ~MCLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge MCLK);
        #1;
    endtask

    task automatic wait_req(output int cycles);
        cycles = 0;
        while (!MEM_REQ && cycles < 20) begin
            step();
            cycles++;
        end
        if (!MEM_REQ) check_val("req_timeout", 32'(MEM_REQ), 32'd1);
    endtask

    task automatic do_ack(input logic [15:0] data);
        MEM_ACK = 1'b1;
        MEM_Q   = data;
        step();
        MEM_ACK = 1'b0;
        MEM_Q   = 16'h0;
    endtask

    task automatic count_reqs(input int n, output int reqs);
        reqs = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (MEM_REQ) reqs++;
        end
    endtask

    int lat;
    int nreq;

    initial begin
        RST_N = 1'b0;
        ROM_ADDR = '0; ROM_CE_N = 1'b1; ROM_OE_N = 1'b1; ROM_WORD = 1'b0;
        BSRAM_ADDR = '0; BSRAM_D = '0; BSRAM_CE_N = 1'b1; BSRAM_OE_N = 1'b1; BSRAM_WE_N = 1'b1;
        MEM_Q = '0; MEM_ACK = 1'b0;
        step(); step();
        check_val("rst_req", 32'(MEM_REQ), 0);
        check_val("rst_busy", 32'(BUSY), 0);
        check_val("rst_romq", 32'(ROM_Q), 0);
        check_val("rst_addr", 32'(MEM_ADDR), 0);
        RST_N = 1'b1;
        step();

        // ROM byte read at odd address
        ROM_ADDR = 23'h000101; ROM_CE_N = 1'b0; ROM_OE_N = 1'b0; ROM_WORD = 1'b0;
        wait_req(lat);
        check_val("t1_latency", 32'(lat), 2);
        check_val("t1_addr", 32'(MEM_ADDR), 32'h000101);
        check_val("t1_we", 32'(MEM_WE), 0);
        check_val("t1_busy", 32'(BUSY), 1);
        step(); step();
        check_val("t1_req_hold", 32'(MEM_REQ), 1);
        do_ack(16'hBEEF);
        check_val("t1_romq", 32'(ROM_Q), 32'h00BE);
        check_val("t1_req_low", 32'(MEM_REQ), 0);
        ROM_CE_N = 1'b1; ROM_OE_N = 1'b1;
        count_reqs(3, nreq);
        check_val("t1_no_repeat", 32'(nreq), 0);

        // BSRAM write
        BSRAM_CE_N = 1'b0; BSRAM_ADDR = 20'h00010; BSRAM_D = 8'h5A; BSRAM_WE_N = 1'b0;
        step();
        BSRAM_WE_N = 1'b1;
        wait_req(lat);
        check_val("t2_we", 32'(MEM_WE), 1);
        check_val("t2_addr", 32'(MEM_ADDR), 32'hE00010);
        check_val("t2_din", 32'(MEM_DIN), 32'h5A);
        step();
        check_val("t2_din_hold", 32'(MEM_DIN), 32'h5A);
        do_ack(16'hFFFF);
        check_val("t2_bsq", 32'(BSRAM_Q), 0);
        BSRAM_CE_N = 1'b1;
        count_reqs(4, nreq);
        check_val("t2_single_req", 32'(nreq), 0);

        // Simultaneous write and ROM word read events
        BSRAM_CE_N = 1'b0; BSRAM_ADDR = 20'h00020; BSRAM_D = 8'h77; BSRAM_WE_N = 1'b0;
        step();
        BSRAM_WE_N = 1'b1;
        ROM_ADDR = 23'h000200; ROM_WORD = 1'b1; ROM_CE_N = 1'b0; ROM_OE_N = 1'b0;
        wait_req(lat);
        check_val("t3_first_we", 32'(MEM_WE), 1);
        check_val("t3_first_addr", 32'(MEM_ADDR), 32'hE00020);
        check_val("t3_first_din", 32'(MEM_DIN), 32'h77);
        do_ack(16'h0);
        check_val("t3_gap_req", 32'(MEM_REQ), 0);
        check_val("t3_gap_busy", 32'(BUSY), 1);
        step();
        check_val("t3_second_req", 32'(MEM_REQ), 1);
        check_val("t3_second_addr", 32'(MEM_ADDR), 32'h000200);
        check_val("t3_second_we", 32'(MEM_WE), 0);
        check_val("t3_second_busy", 32'(BUSY), 1);
        do_ack(16'h1234);
        check_val("t3_romq_word", 32'(ROM_Q), 32'h1234);
        check_val("t3_busy_done", 32'(BUSY), 0);
        BSRAM_CE_N = 1'b1; ROM_CE_N = 1'b1; ROM_OE_N = 1'b1; ROM_WORD = 1'b0;
        step();

        // Address sweep while a request is outstanding: coalesced to latest
        ROM_ADDR = 23'h000010; ROM_CE_N = 1'b0; ROM_OE_N = 1'b0;
        wait_req(lat);
        check_val("t4_addr0", 32'(MEM_ADDR), 32'h000010);
        ROM_ADDR = 23'h000011;
        step();
        ROM_ADDR = 23'h000012;
        step(); step();
        do_ack(16'h2211);
        check_val("t4_romq0", 32'(ROM_Q), 32'h0011);
        wait_req(lat);
        check_val("t4_addr1", 32'(MEM_ADDR), 32'h000012);
        do_ack(16'h4433);
        check_val("t4_romq1", 32'(ROM_Q), 32'h0033);
        count_reqs(4, nreq);
        check_val("t4_no_third", 32'(nreq), 0);
        ROM_CE_N = 1'b1; ROM_OE_N = 1'b1;
        step();

        // Reset while a request is outstanding; late ACK must be ignored
        ROM_ADDR = 23'h000300; ROM_CE_N = 1'b0; ROM_OE_N = 1'b0;
        wait_req(lat);
        check_val("t5_req_before", 32'(MEM_REQ), 1);
        RST_N = 1'b0;
        #1;
        check_val("t5_req_rst", 32'(MEM_REQ), 0);
        check_val("t5_busy_rst", 32'(BUSY), 0);
        check_val("t5_romq_rst", 32'(ROM_Q), 0);
        check_val("t5_addr_rst", 32'(MEM_ADDR), 0);
        ROM_CE_N = 1'b1; ROM_OE_N = 1'b1;
        step();
        RST_N = 1'b1;
        step(); step();
        do_ack(16'hDEAD);
        check_val("t5_romq_after", 32'(ROM_Q), 0);
        check_val("t5_req_after", 32'(MEM_REQ), 0);
        check_val("t5_busy_after", 32'(BUSY), 0);

        // BSRAM read at odd address, strobes dropped before the ACK
        BSRAM_ADDR = 20'h00033; BSRAM_CE_N = 1'b0; BSRAM_OE_N = 1'b0; BSRAM_WE_N = 1'b1;
        wait_req(lat);
        check_val("t6_addr", 32'(MEM_ADDR), 32'hE00033);
        check_val("t6_we", 32'(MEM_WE), 0);
        BSRAM_CE_N = 1'b1; BSRAM_OE_N = 1'b1;
        step();
        check_val("t6_req_kept", 32'(MEM_REQ), 1);
        do_ack(16'hA5C3);
        check_val("t6_bsq", 32'(BSRAM_Q), 32'hA5);
        check_val("t6_romq_held", 32'(ROM_Q), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
